// File: rtl/mem_bus_pkg.sv
// Shared types for the memory-bus sequencer: FSM states, bus owner, wait counter width.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  // Width of the wait-state counter; WAIT_CYCLES must fit (0..15).
  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Bundle of the CPU, debug and SRAM-side signals of the memory-bus sequencer.
// slave: the sequencer itself. master: the requesters plus the memory.
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_ce, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_rr_arb.sv
// Two-input round-robin arbiter. On a tie the requester that was not served
// last wins. last_grant resets to DBG so the CPU wins the first tie.
module mem_rr_arb
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic       dbg_req,
  input  logic       grant_done,
  input  owner_t     done_owner,
  output logic [1:0] gnt          // [0]=CPU, [1]=DBG, one-hot or zero
);

  owner_t last_grant_q, last_grant_d;

  // Grant decode: single requester wins outright, tie goes to the other side.
  always_comb begin
    gnt = {dbg_req, cpu_req};
    if (cpu_req && dbg_req)
      gnt = (last_grant_q == OWN_DBG) ? 2'b01 : 2'b10;
  end

  // Remember who completed last.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_done) last_grant_d = done_owner;
  end

  // last_grant register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= OWN_DBG;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus sequencer: arbitrates CPU and debug requests onto one SRAM port,
// holds the access for WAIT_CYCLES extra cycles, then pulses done/ack.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst_n,
  mem_bus_ctrl_if.slave  bus
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                cpu_req, grant_done;
  logic [1:0]          gnt;

  assign cpu_req = bus.cpu_rd | bus.cpu_wr;

  mem_rr_arb u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .dbg_req    (bus.dbg_req),
    .grant_done (grant_done),
    .done_owner (owner_q),
    .gnt        (gnt)
  );

  // Sequencer: grant in IDLE, count wait states in ACCESS, one-cycle RESP.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    wcnt_d      = wcnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    grant_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt[0]) begin
          owner_d = OWN_CPU;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          we_d    = bus.cpu_wr;          // rd+wr together is a write
          wcnt_d  = WAIT_INIT;
          state_d = ST_ACCESS;
        end else if (gnt[1]) begin
          owner_d = OWN_DBG;
          addr_d  = bus.dbg_addr;
          wdata_d = bus.dbg_wdata;
          we_d    = bus.dbg_we;
          wcnt_d  = WAIT_INIT;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else begin
          if (!we_q) begin
            if (owner_q == OWN_CPU) cpu_rdata_d = bus.mem_rdata;
            else                    dbg_rdata_d = bus.mem_rdata;
          end
          grant_done = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wcnt_q      <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      wcnt_q      <= wcnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Outputs decode straight from registered state, so reset drops them at once.
  always_comb begin
    bus.mem_ce    = (state_q == ST_ACCESS);
    bus.mem_we    = (state_q == ST_ACCESS) & we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.cpu_rdata = cpu_rdata_q;
    bus.dbg_rdata = dbg_rdata_q;
    bus.cpu_done  = (state_q == ST_RESP) & (owner_q == OWN_CPU);
    bus.dbg_ack   = (state_q == ST_RESP) & (owner_q == OWN_DBG);
    bus.cpu_stall = cpu_req & ~bus.cpu_done;
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboarded bench for mem_bus_ctrl with a 16-word SRAM model, WAIT_CYCLES=2.
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // SRAM model: unwritten words return a fixed per-address pattern.
  logic [31:0] mem_arr [16];
  bit          mem_wr  [16];
  logic [3:0]  mem_idx;

  function automatic logic [31:0] init_word(int idx);
    return (idx == 1) ? 32'h8C010001 : {16'hA5A5, 16'(idx)};
  endfunction

  assign mem_idx       = bus.mem_addr[5:2];
  assign bus.mem_rdata = mem_wr[mem_idx] ? mem_arr[mem_idx] : init_word(int'(mem_idx));

  always @(posedge clk)
    if (bus.mem_ce && bus.mem_we) begin
      mem_arr[mem_idx] <= bus.mem_wdata;
      mem_wr[mem_idx]  <= 1'b1;
    end

  // Bench-side expectation of memory contents.
  logic [31:0] shadow    [16];
  bit          shadow_wr [16];

  function automatic logic [31:0] exp_word(int idx);
    return shadow_wr[idx] ? shadow[idx] : init_word(idx);
  endfunction

  int errs = 0;
  int checks = 0;
  logic [31:0] cpu_q [$];
  logic [31:0] dbg_q [$];
  int          order_q [$];
  logic [31:0] exp_cpu_rd = '0;
  logic [31:0] exp_dbg_rd = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drop_req(input int who);
    if (who == 0) begin bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; end
    else          bus.dbg_req = 1'b0;
  endtask

  // One access. Call just after a negedge; that cycle is cycle 0.
  // With timed=1 the bus waveform and done timing are checked cycle by cycle.
  task automatic xfer(input int who, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input bit timed, input string tag, output int lat);
    int idx;
    logic done;
    logic [31:0] got, exp;
    idx = int'(addr[5:2]);
    if (wr) begin
      shadow[idx] = wdata; shadow_wr[idx] = 1'b1;
    end else if (who == 0) exp_cpu_rd = exp_word(idx);
    else                   exp_dbg_rd = exp_word(idx);
    if (who == 0) cpu_q.push_back(exp_cpu_rd);
    else          dbg_q.push_back(exp_dbg_rd);
    if (who == 0) begin
      bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end else begin
      bus.dbg_req = 1'b1; bus.dbg_we = wr; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    end
    lat = -1;
    for (int c = 0; c < 30; c++) begin
      #1;
      done = (who == 0) ? bus.cpu_done : bus.dbg_ack;
      if (timed) begin
        chk({tag, "_ce"}, bus.mem_ce, (c >= 1 && c <= W + 1));
        if (c >= 1 && c <= W + 1) begin
          chk({tag, "_addr"}, bus.mem_addr, addr);
          chk({tag, "_we"}, bus.mem_we, wr);
          if (wr) chk({tag, "_wdata"}, bus.mem_wdata, wdata);
        end
        if (who == 0) chk({tag, "_stall"}, bus.cpu_stall, (c <= W + 1));
        chk({tag, "_done"}, done, (c == W + 2));
      end
      if (done) begin
        lat = c;
        order_q.push_back(who);
        if (who == 0) begin got = bus.cpu_rdata; exp = cpu_q.pop_front(); end
        else          begin got = bus.dbg_rdata; exp = dbg_q.pop_front(); end
        chk({tag, "_rdata"}, got, exp);
        drop_req(who);
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      chk({tag, "_timeout"}, 1'b0, 1'b1);
      drop_req(who);
      if (who == 0) void'(cpu_q.pop_front());
      else          void'(dbg_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    int lat, lat_c, lat_d, ndone;
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ce", bus.mem_ce, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_rdata", {bus.cpu_rdata, bus.dbg_rdata}, 64'h0);
    chk("rst_done", {bus.cpu_done, bus.dbg_ack, bus.cpu_stall}, 3'b000);
    rst_n = 1'b1;

    // CPU read of 0x4.
    @(negedge clk);
    xfer(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, "cpu_rd", lat);
    chk("cpu_rd_val", bus.cpu_rdata, 32'h8C010001);

    // CPU write; rdata must be untouched afterwards.
    @(negedge clk);
    xfer(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, "cpu_wr", lat);
    @(negedge clk);
    chk("cpu_wr_keep", bus.cpu_rdata, 32'h8C010001);
    xfer(1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, "dbg_rd", lat);

    // rd+wr together performs a write.
    @(negedge clk);
    xfer(0, 1'b1, 1'b1, 32'h14, 32'h12345678, 1'b1, "cpu_rdwr", lat);
    @(negedge clk);
    chk("cpu_rdwr_keep", bus.cpu_rdata, 32'h8C010001);
    xfer(1, 1'b0, 1'b0, 32'h14, 32'h0, 1'b1, "dbg_rd2", lat);

    // Debug write then readback at max-index word.
    @(negedge clk);
    xfer(1, 1'b0, 1'b1, 32'h3C, 32'hCAFEF00D, 1'b1, "dbg_wr", lat);
    @(negedge clk);
    chk("dbg_wr_keep", bus.dbg_rdata, 32'h12345678);
    xfer(0, 1'b1, 1'b0, 32'h3C, 32'h0, 1'b1, "cpu_rd2", lat);

    // Reset during cycle 2 of a read.
    @(negedge clk);
    bus.cpu_rd = 1'b1; bus.cpu_addr = 32'h8;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort_ce_before", bus.mem_ce, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_ce", bus.mem_ce, 1'b0);
    chk("abort_done", bus.cpu_done, 1'b0);
    chk("abort_rdata", bus.cpu_rdata, 32'h0);
    chk("abort_addr", bus.mem_addr, 32'h0);
    exp_cpu_rd = '0;
    bus.cpu_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.cpu_done || bus.mem_ce) ndone++;
    end
    chk("abort_quiet", ndone, 0);
    chk("abort_idle", dut.state_q, ST_IDLE);

    // Tie right after reset: CPU first (done cycle 4), DBG ack cycle 9.
    order_q.delete();
    @(negedge clk);
    fork
      xfer(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, "tie_cpu", lat_c);
      xfer(1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, "tie_dbg", lat_d);
    join
    chk("tie_cpu_lat", lat_c, W + 2);
    chk("tie_dbg_lat", lat_d, 2 * W + 5);

    // Fairness: both re-request back-to-back; grants must alternate.
    order_q.delete();
    fork
      begin
        int lc;
        for (int n = 0; n < 3; n++) begin
          @(negedge clk);
          xfer(0, n != 0, n == 0, 32'h20, 32'h11110000 + n, 1'b0, "fair_cpu", lc);
          chk("fair_cpu_lat", lc <= 2 * W + 5, 1'b1);
        end
      end
      begin
        int ld;
        for (int n = 0; n < 3; n++) begin
          @(negedge clk);
          xfer(1, 1'b0, n == 0, 32'h24, 32'h22220000 + n, 1'b0, "fair_dbg", ld);
          chk("fair_dbg_lat", ld <= 2 * W + 5, 1'b1);
        end
      end
    join
    chk("fair_count", order_q.size(), 6);
    for (int i = 0; i < order_q.size(); i++)
      chk("fair_order", order_q[i], i % 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
